hazard_sb: RTL

Next-generation pipeline hazard unit for the 5-stage MIPS core, with latencies set by parameters. It keeps the existing M/W bypass selects, load-use and branch stalls. It adds three things:
- an internal multiply/divide busy tracker (FSM plus down-counter), replacing the external "computing" flag;
- a data-memory wait input that freezes F..M;
- a precise-exception flush that overrides every stall.

---
 rtl/hazard_pkg.sv | 19 +
 rtl/hazard_sb_if.sv | 43 ++++
 rtl/hazard_mdu_tracker.sv | 63 ++++++
 rtl/hazard_sb.sv | 102 ++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared constants, MDU state type and latency helper for the hazard unit
package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } mdu_state_t;

  // Larger of the two MDU latencies; sizes the shared down-counter.
  function automatic int max_lat(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hazard_sb_if.sv
// rtl/hazard_sb_if.sv - pipeline-to-hazard-unit signal bundle
interface hazard_sb_if #(
  parameter int REG_AW = 5
);

  logic [REG_AW-1:0] rsD, rtD;
  logic              branchD;
  logic [REG_AW-1:0] rsE, rtE, writeregE;
  logic              regwriteE, memtoregE;
  logic              mdu_startE, mdu_is_divE;
  logic [REG_AW-1:0] writeregM;
  logic              regwriteM, memtoregM;
  logic              dmem_waitM, excflushM;
  logic [REG_AW-1:0] writeregW;
  logic              regwriteW;

  logic              forwardaD, forwardbD;
  logic [1:0]        forwardaE, forwardbE;
  logic              stallF, stallD, stallE, stallM, stallW;
  logic              flushD, flushE, flushM, flushW;
  logic              mdu_busy, mdu_done;

  // Pipeline side: supplies stage state, receives selects and stall/flush controls.
  modport master (
    output rsD, rtD, branchD, rsE, rtE, writeregE, regwriteE, memtoregE,
           mdu_startE, mdu_is_divE, writeregM, regwriteM, memtoregM,
           dmem_waitM, excflushM, writeregW, regwriteW,
    input  forwardaD, forwardbD, forwardaE, forwardbE,
           stallF, stallD, stallE, stallM, stallW,
           flushD, flushE, flushM, flushW, mdu_busy, mdu_done
  );

  // Hazard unit side.
  modport slave (
    input  rsD, rtD, branchD, rsE, rtE, writeregE, regwriteE, memtoregE,
           mdu_startE, mdu_is_divE, writeregM, regwriteM, memtoregM,
           dmem_waitM, excflushM, writeregW, regwriteW,
    output forwardaD, forwardbD, forwardaE, forwardbE,
           stallF, stallD, stallE, stallM, stallW,
           flushD, flushE, flushM, flushW, mdu_busy, mdu_done
  );

endinterface

// File: rtl/hazard_mdu_tracker.sv
// rtl/hazard_mdu_tracker.sv - multiply/divide occupancy FSM with latency down-counter
module hazard_mdu_tracker
  import hazard_pkg::*;
#(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = $clog2(max_lat(MUL_LAT, DIV_LAT) + 1)
) (
  input  logic clk,
  input  logic resetn,
  input  logic start,
  input  logic is_div,
  input  logic hold,
  input  logic abort,
  output logic busy,
  output logic done
);

  mdu_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] load_val;

  // cnt holds the BUSY cycles still owed after the current one, so the
  // BUSY->DONE step happens as cnt steps from 1 to 0. A latency of 1
  // therefore skips BUSY and lands in DONE straight from IDLE.
  assign load_val = is_div ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);

  // State and counter update; abort wins over everything except reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (abort) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !hold) begin
            state <= (load_val == '0) ? DONE : BUSY;
            cnt   <= load_val;
          end
        end
        BUSY: begin
          if (!hold) begin
            if (cnt <= CNT_W'(1)) begin
              state <= DONE;
              cnt   <= '0;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == BUSY);
  assign done = (state == DONE);

endmodule

// File: rtl/hazard_sb.sv
// rtl/hazard_sb.sv - 5-stage pipeline hazard unit: bypass selects, stalls, flushes, MDU tracking
module hazard_sb
  import hazard_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = $clog2(max_lat(MUL_LAT, DIV_LAT) + 1)
) (
  input  logic       clk,
  input  logic       resetn,
  hazard_sb_if.slave bus
);

  localparam logic [REG_AW-1:0] ZERO_REG = '0;

  logic lw_stall, br_stall, mdu_hold;
  logic busy, done;

  hazard_mdu_tracker #(
    .MUL_LAT(MUL_LAT),
    .DIV_LAT(DIV_LAT),
    .CNT_W  (CNT_W)
  ) u_tracker (
    .clk   (clk),
    .resetn(resetn),
    .start (bus.mdu_startE),
    .is_div(bus.mdu_is_divE),
    .hold  (bus.dmem_waitM),
    .abort (bus.excflushM),
    .busy  (busy),
    .done  (done)
  );

  assign bus.mdu_busy = busy;
  assign bus.mdu_done = done;

  // E-stage bypass selects: the younger M result beats W; r0 never forwards.
  always_comb begin
    bus.forwardaE = FWD_RF;
    bus.forwardbE = FWD_RF;
    if (bus.rsE != ZERO_REG && bus.regwriteM && bus.rsE == bus.writeregM)
      bus.forwardaE = FWD_MEM;
    else if (bus.rsE != ZERO_REG && bus.regwriteW && bus.rsE == bus.writeregW)
      bus.forwardaE = FWD_WB;
    if (bus.rtE != ZERO_REG && bus.regwriteM && bus.rtE == bus.writeregM)
      bus.forwardbE = FWD_MEM;
    else if (bus.rtE != ZERO_REG && bus.regwriteW && bus.rtE == bus.writeregW)
      bus.forwardbE = FWD_WB;
  end

  assign bus.forwardaD = (bus.rsD != ZERO_REG) && bus.regwriteM && (bus.rsD == bus.writeregM);
  assign bus.forwardbD = (bus.rtD != ZERO_REG) && bus.regwriteM && (bus.rtD == bus.writeregM);

  assign lw_stall = bus.memtoregE && (bus.writeregE != ZERO_REG) &&
                    ((bus.writeregE == bus.rsD) || (bus.writeregE == bus.rtD));

  assign br_stall = bus.branchD &&
                    ((bus.regwriteE && (bus.writeregE != ZERO_REG) &&
                      ((bus.writeregE == bus.rsD) || (bus.writeregE == bus.rtD))) ||
                     (bus.memtoregM && (bus.writeregM != ZERO_REG) &&
                      ((bus.writeregM == bus.rsD) || (bus.writeregM == bus.rtD))));

  // The mul/div owns E while counting, and also in the IDLE cycle it first
  // appears; in DONE the result is ready and E is allowed to advance.
  assign mdu_hold = busy || (bus.mdu_startE && !busy && !done);

  // Priority mux: exception flush, memory wait, MDU hold, load-use/branch.
  always_comb begin
    bus.stallF = 1'b0;
    bus.stallD = 1'b0;
    bus.stallE = 1'b0;
    bus.stallM = 1'b0;
    bus.stallW = 1'b0;
    bus.flushD = 1'b0;
    bus.flushE = 1'b0;
    bus.flushM = 1'b0;
    bus.flushW = 1'b0;
    if (bus.excflushM) begin
      bus.flushD = 1'b1;
      bus.flushE = 1'b1;
      bus.flushM = 1'b1;
      bus.flushW = 1'b1;
    end else if (bus.dmem_waitM) begin
      bus.stallF = 1'b1;
      bus.stallD = 1'b1;
      bus.stallE = 1'b1;
      bus.stallM = 1'b1;
      bus.flushW = 1'b1;
    end else if (mdu_hold) begin
      bus.stallF = 1'b1;
      bus.stallD = 1'b1;
      bus.stallE = 1'b1;
      bus.flushM = 1'b1;
    end else if (lw_stall || br_stall) begin
      bus.stallF = 1'b1;
      bus.stallD = 1'b1;
      bus.flushE = 1'b1;
    end
  end

endmodule
